// File: rtl/rf_wb_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter.
// Used by rf_wb_arbiter and rr_pick.
package rf_wb_pkg;

   localparam int NREQ_DEF = 3;
   localparam int AW_DEF   = 4;
   localparam int DW_DEF   = 4;

   // Widest lane and widest packed bus the lane extractor handles
   localparam int LANE_MAX = 32;
   localparam int BUS_MAX  = 256;

   // The link register is the highest-numbered register; users slice the low AW bits
   localparam logic [LANE_MAX-1:0] LINK_ADDR = '1;

   function automatic logic [LANE_MAX-1:0] get_lane(input logic [BUS_MAX-1:0] bus,
                                                     input int idx,
                                                     input int w);
      logic [LANE_MAX-1:0] mask;
      mask = (w >= LANE_MAX) ? '1 : ((LANE_MAX'(1) << w) - LANE_MAX'(1));
      return LANE_MAX'(bus >> (idx * w)) & mask;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of vld at or after ptr,
// wrapping modulo NREQ. Holds no state.
module rr_pick #(
   parameter int NREQ = 3,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] vld,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   idx,
   output logic            any
);

   int j;

   // NOTE: every output and temporary gets a default before the loop, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!any && vld[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = PW'(j);
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: one-entry buffer per requester, round-robin
// issue, link (save-PC) priority. Optional macro RF_WB_ZERO_DISCARD_EN drops writes to r0.
module rf_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic              link_req,
   input  logic [31:0]       link_pc,
   output logic              rf_we,
   output logic [AW-1:0]     rf_wa,
   output logic [DW-1:0]     rf_wd,
   output logic              rf_save_pc,
   output logic [31:0]       rf_pc,
   input  logic [AW-1:0]     q_addr,
   output logic              q_hit,
   output logic              idle
);

   localparam int PW = $clog2(NREQ);
   localparam logic [AW-1:0] LINK_A = LINK_ADDR[AW-1:0];

   logic [NREQ-1:0] r_buf_vld;
   logic [AW-1:0]   r_buf_addr [NREQ];
   logic [DW-1:0]   r_buf_data [NREQ];
   logic            r_link_pend;
   logic [31:0]     r_link_pc;
   logic [PW-1:0]   r_rr_ptr;

   logic [NREQ-1:0] w_pick_grant;
   logic [NREQ-1:0] w_grant;
   logic [NREQ-1:0] w_store;
   logic [PW-1:0]   w_pick_idx;
   logic            w_pick_any;
   logic            w_issue;
   logic [AW-1:0]   w_lane_addr [NREQ];
   logic [DW-1:0]   w_lane_data [NREQ];

   rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .vld   (r_buf_vld),
      .ptr   (r_rr_ptr),
      .grant (w_pick_grant),
      .idx   (w_pick_idx),
      .any   (w_pick_any)
   );

   // A pending link save owns the issue slot, so no buffer is granted that cycle
   assign w_issue   = w_pick_any & ~r_link_pend;
   assign w_grant   = w_issue ? w_pick_grant : '0;
   assign req_ready = ~r_buf_vld | w_grant;

   // NOTE: combinational logic uses blocking '=' so later statements see the
   // updated value; clocked state below uses non-blocking '<=' only.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         w_lane_addr[i] = AW'(get_lane(BUS_MAX'(req_addr), i, AW));
         w_lane_data[i] = DW'(get_lane(BUS_MAX'(req_data), i, DW));
         w_store[i]     = req_valid[i] & req_ready[i];
`ifdef RF_WB_ZERO_DISCARD_EN
         if (w_lane_addr[i] == '0) w_store[i] = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf_vld <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (w_store[i])      r_buf_vld[i] <= 1'b1;
            else if (w_grant[i]) r_buf_vld[i] <= 1'b0;
         end
      end
   end

   // NOTE: buffer payload has no reset; r_buf_vld qualifies it, so stale
   // contents after reset are never observed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (w_store[i]) begin
            r_buf_addr[i] <= w_lane_addr[i];
            r_buf_data[i] <= w_lane_data[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_link_pend <= 1'b0;
         r_link_pc   <= '0;
         r_rr_ptr    <= '0;
         rf_we       <= 1'b0;
         rf_wa       <= '0;
         rf_wd       <= '0;
         rf_save_pc  <= 1'b0;
         rf_pc       <= '0;
      end else begin
         // A new link request wins over clearing, so a save arriving as the
         // previous one issues becomes pending for the next cycle
         if (link_req) begin
            r_link_pend <= 1'b1;
            r_link_pc   <= link_pc;
         end else if (r_link_pend) begin
            r_link_pend <= 1'b0;
         end

         rf_save_pc <= r_link_pend;
         if (r_link_pend) rf_pc <= r_link_pc;

         rf_we <= w_issue;
         if (w_issue) begin
            rf_wa    <= r_buf_addr[w_pick_idx];
            rf_wd    <= r_buf_data[w_pick_idx];
            r_rr_ptr <= (w_pick_idx == PW'(NREQ - 1)) ? '0 : w_pick_idx + 1'b1;
         end
      end
   end

   always_comb begin
      q_hit = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_buf_vld[i] && (r_buf_addr[i] == q_addr)) q_hit = 1'b1;
      end
      if (rf_we && (rf_wa == q_addr)) q_hit = 1'b1;
      if ((r_link_pend || rf_save_pc) && (q_addr == LINK_A)) q_hit = 1'b1;
   end

   assign idle = ~|r_buf_vld & ~r_link_pend & ~rf_we & ~rf_save_pc;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (NREQ=3, AW=4, DW=4).
// Covers both builds of RF_WB_ZERO_DISCARD_EN.
module tb_rf_wb_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 4;
   localparam int DW   = 4;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic              link_req;
   logic [31:0]       link_pc;
   logic              rf_we;
   logic [AW-1:0]     rf_wa;
   logic [DW-1:0]     rf_wd;
   logic              rf_save_pc;
   logic [31:0]       rf_pc;
   logic [AW-1:0]     q_addr;
   logic              q_hit;
   logic              idle;

   int n_cmp = 0;
   int n_mis = 0;

   rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .link_req   (link_req),
      .link_pc    (link_pc),
      .rf_we      (rf_we),
      .rf_wa      (rf_wa),
      .rf_wd      (rf_wd),
      .rf_save_pc (rf_save_pc),
      .rf_pc      (rf_pc),
      .q_addr     (q_addr),
      .q_hit      (q_hit),
      .idle       (idle)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i]          = v;
      req_addr[i*AW +: AW]  = a;
      req_data[i*DW +: DW]  = d;
   endtask

   task automatic clear_inputs();
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      link_req  = 1'b0;
      link_pc   = '0;
      q_addr    = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      #2;
      check("reset_we",    rf_we, 0);
      check("reset_save",  rf_save_pc, 0);
      check("reset_pc",    rf_pc, 0);
      check("reset_wa_wd", {rf_wa, rf_wd}, 0);
      check("reset_ready", req_ready, 3'b111);
      check("reset_idle",  idle, 1);
      step();
      rst_n = 1'b1;

      // Single write
      set_req(0, 1'b1, 4'd5, 4'hA);
      q_addr = 4'd5;
      step();
      set_req(0, 1'b0, 4'd0, 4'h0);
      check("single_e1_we",   rf_we, 0);
      check("single_e1_idle", idle, 0);
      check("single_e1_qhit", q_hit, 1);
      step();
      check("single_e2_we", rf_we, 1);
      check("single_e2_wa", rf_wa, 5);
      check("single_e2_wd", rf_wd, 4'hA);
      step();
      check("single_e3_we",   rf_we, 0);
      check("single_e3_hold", {rf_wa, rf_wd}, {4'd5, 4'hA});
      check("single_e3_idle", idle, 1);

      // Contention, round-robin from rr_ptr=0
      do_reset();
      set_req(0, 1'b1, 4'd1, 4'd1);
      set_req(1, 1'b1, 4'd2, 4'd2);
      set_req(2, 1'b1, 4'd3, 4'd3);
      step();
      clear_inputs();
      check("cont_e1_ready", req_ready, 3'b001);
      step();
      check("cont_e2", {rf_we, rf_wa}, {1'b1, 4'd1});
      step();
      check("cont_e3", {rf_we, rf_wa}, {1'b1, 4'd2});
      step();
      check("cont_e4", {rf_we, rf_wa}, {1'b1, 4'd3});
      set_req(0, 1'b1, 4'd4, 4'd6);
      set_req(2, 1'b1, 4'd8, 4'd7);
      step();
      clear_inputs();
      check("cont_e5_we", rf_we, 0);
      step();
      check("cont_e6", {rf_we, rf_wa, rf_wd}, {1'b1, 4'd4, 4'd6});
      step();
      check("cont_e7", {rf_we, rf_wa, rf_wd}, {1'b1, 4'd8, 4'd7});
      step();
      check("cont_e8_idle", idle, 1);

      // Link priority over a buffered write
      do_reset();
      set_req(1, 1'b1, 4'd7, 4'd5);
      link_req = 1'b1;
      link_pc  = 32'h100;
      q_addr   = 4'd15;
      step();
      set_req(1, 1'b0, 4'd0, 4'd0);
      link_req = 1'b0;
      link_pc  = 32'h0;
      check("link_e1_save",  rf_save_pc, 0);
      check("link_e1_ready", req_ready[1], 0);
      check("link_e1_qhit",  q_hit, 1);
      step();
      check("link_e2", {rf_save_pc, rf_we, rf_pc}, {1'b1, 1'b0, 32'h100});
      check("link_e2_qhit", q_hit, 1);
      step();
      check("link_e3", {rf_save_pc, rf_we, rf_wa, rf_wd}, {1'b0, 1'b1, 4'd7, 4'd5});
      check("link_e3_pc_hold", rf_pc, 32'h100);
      check("link_e3_qhit", q_hit, 0);

      // Streaming from requester 0
      do_reset();
      for (int k = 0; k < 8; k++) begin
         set_req(0, 1'b1, 4'd2, 4'(k));
         check($sformatf("stream_ready_%0d", k), req_ready[0], 1);
         step();
         if (k >= 1) check($sformatf("stream_wd_%0d", k - 1), {rf_we, rf_wd}, {1'b1, 4'(k - 1)});
      end
      clear_inputs();
      step();
      check("stream_wd_7", {rf_we, rf_wd}, {1'b1, 4'd7});
      step();
      check("stream_end_we", rf_we, 0);

      // Hazard query
      do_reset();
      set_req(2, 1'b1, 4'd9, 4'd3);
      q_addr = 4'd9;
      step();
      set_req(2, 1'b0, 4'd0, 4'd0);
      check("haz_buf_hit", q_hit, 1);
      q_addr = 4'd4;
      #1;
      check("haz_other_miss", q_hit, 0);
      q_addr = 4'd9;
      step();
      check("haz_flight_hit", {rf_we, q_hit}, 2'b11);
      step();
      check("haz_done_miss", {rf_we, q_hit}, 2'b00);

      // Reset mid-operation
      do_reset();
      set_req(0, 1'b1, 4'd1, 4'd1);
      set_req(1, 1'b1, 4'd2, 4'd2);
      set_req(2, 1'b1, 4'd3, 4'd3);
      step();
      step();
      check("mid_pre_we", rf_we, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_outs", {rf_we, rf_save_pc, rf_wa, rf_wd, rf_pc}, 0);
      check("mid_rst_ready", req_ready, 3'b111);
      check("mid_rst_idle", idle, 1);
      clear_inputs();
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("mid_post_we_%0d", k), {rf_we, idle}, 2'b01);
      end

      // Writes to register 0
      do_reset();
      set_req(0, 1'b1, 4'd0, 4'd9);
      q_addr = 4'd0;
      #1;
      check("zero_ready", req_ready[0], 1);
      step();
      clear_inputs();
`ifdef RF_WB_ZERO_DISCARD_EN
      check("zero_e1_qhit", q_hit, 0);
      check("zero_e1_idle", idle, 1);
      step();
      check("zero_e2_we", rf_we, 0);
`else
      check("zero_e1_qhit", q_hit, 1);
      step();
      check("zero_e2", {rf_we, rf_wa, rf_wd}, {1'b1, 4'd0, 4'd9});
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the register file's single write port and its save-PC (link) path among NREQ writeback requesters, e.g. ALU, load unit and terminal/debug writes.
- Each requester gets a one-entry holding buffer.
- Occupied buffers are served round-robin, one write per cycle.
- Link saves take priority.
- A combinational pending-write query lets the decode stage stall on registers with writes still in flight.

Parameters:
NREQ, 3, number of write requesters (2..8)
AW, 4, register address width (register file M+1)
DW, 4, register data width (register file N+1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester write request
req_ready  output  NREQ  per-requester accept
req_addr  input  NREQ*AW  packed; requester i at [i*AW +: AW]
req_data  input  NREQ*DW  packed; requester i at [i*DW +: DW]
link_req  input  1  single-cycle pulse: save PC+4 into link register
link_pc  input  32  PC sampled with link_req
rf_we  output  1  register file write enable (registered)
rf_wa  output  AW  register file write address (registered)
rf_wd  output  DW  register file write data (registered)
rf_save_pc  output  1  register file save_pc (registered)
rf_pc  output  32  register file PC input (registered)
q_addr  input  AW  pending-write query address
q_hit  output  1  combinational: write to q_addr buffered or in flight
idle  output  1  no buffered, pending or in-flight writes

Behaviour:
- Reset (async, rst_n=0): all outputs 0. All buffers empty, link_pend=0, rr_ptr=0. In-flight and buffered writes are discarded; no RF write occurs during or after reset.
- Buffer i accepts on req_valid[i] & req_ready[i] at a rising edge.
- req_ready[i] = ~buf_vld[i] | grant[i]. A granted buffer refills in the same cycle, so one requester alone sustains 1 write/cycle.
- Issue stage, once per cycle, combinational from current state:
  - If link_pend: register rf_save_pc=1, rf_we=0, rf_pc=link_pc_q; clear link_pend; no grant this cycle.
  - Else if any buf_vld: grant the first occupied index at or after rr_ptr, wrapping modulo NREQ. Register rf_we=1 with that buffer's addr/data; clear the buffer; rr_ptr <= grant+1, mod NREQ.
  - Else rf_we=0, rf_save_pc=0.
  - rf_we and rf_save_pc are never 1 together.
- Latency: accepted at edge T → rf_we high in cycle after edge T+1 → RF written at edge T+2. Link: link_req at edge T → rf_save_pc high after edge T+1.
- link_req while link_pend=1: link_pc_q overwritten (latest wins), only one save issued.
- link_req in the same cycle the pending link issues: new link becomes pending, issued next cycle.
- Ordering:
  - Strict per requester.
  - Undefined across requesters for the same address; software and the pipeline must avoid this.
- q_hit = OR over i of (buf_vld[i] & buf_addr[i]==q_addr) | (rf_we & rf_wa==q_addr) | ((link_pend|rf_save_pc) & q_addr=={AW{1'b1}}).
- idle = ~|buf_vld & ~link_pend & ~rf_we & ~rf_save_pc.
- rf_wa/rf_wd/rf_pc hold their last values when the enables are low.

Optional Feature:
RF_WB_ZERO_DISCARD_EN
- Defined: requests with addr 0 are accepted (ready asserted as usual) but never buffered or issued, and never raise q_hit. Register 0 stays 0 after reset.
- Undefined: addr 0 is written like any other register.

Decomposition:
- Package rf_wb_pkg holds:
  - the default AW/DW/NREQ constants;
  - the LINK_ADDR constant (all-ones);
  - the function that extracts a packed lane.
- Sub-module rr_pick(NREQ): combinational round-robin picker, inputs vld and ptr, outputs one-hot grant, index and any. Instantiated once; holds no state.

Test Plan:
- Single write: req0 addr=5 data=0xA at edge 1 → rf_we=1, rf_wa=5, rf_wd=0xA after edge 2 for exactly one cycle; idle=1 after edge 3.
- Contention: req0/1/2 valid at edge 1 with addr 1/2/3 → writes to 1, 2, 3 after edges 2, 3, 4.
  - Second round, req0/req2 both valid at edge 5 with rr_ptr=0 → req0 then req2.
- Link priority: req1 addr=7 buffered, link_req with pc=0x100 at the same edge → rf_save_pc=1, rf_pc=0x100 first; rf_we, wa=7 one cycle later.
- Streaming: req0 held valid 8 cycles with data 0..7, others idle → req_ready[0] stays 1; rf_we high 8 consecutive cycles, data 0..7 in order.
- Hazard: req2 addr=9 buffered, q_addr=9 → q_hit=1 until the cycle after rf_we drops; q_addr=15 with link pending → q_hit=1.
- Reset mid-operation: rst_n low while 3 buffers are full and rf_we=1 → all outputs 0 immediately, no write after rst_n rises, req_ready all 1.
- Feature variant: with RF_WB_ZERO_DISCARD_EN defined, addr 0 request → accepted, no rf_we.
